// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the parametrised UART receiver.
// Receiver state encoding, parity modes and the baud divider helper.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Rounded clocks-per-oversample-tick, never below one.
    function automatic int calc_div(
        input int clk_hz,
        input int baud,
        input int os
    );
        int den;
        int d;
        den = baud * os;
        d   = (clk_hz + den / 2) / den;
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-cycle tick.
// The tick is a clock enable for the receiver, never a clock.
`timescale 1ns/1ps
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk50,
    input  logic nreset,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Wrap the divider after DIV clocks.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) cnt_d = '0;
    end

    // Divider register, restarts from zero on reset.
    always_ff @(posedge clk50 or negedge nreset) begin
        if (!nreset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority vote,
// false-start rejection, parity/framing flags and valid/ready output.
`timescale 1ns/1ps
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk50,
    input  logic                 nreset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TC_M0   = TW'(M - 1);
    localparam logic [TW-1:0] TC_M1   = TW'(M);
    localparam logic [TW-1:0] TC_M2   = TW'(M + 1);
    localparam logic [BW-1:0] NBITS   = BW'(DATA_BITS);
    localparam logic [BW-1:0] SB_LAST = BW'(STOP_BITS - 1);
    localparam logic          IS_ODD  = (PARITY == PAR_ODD);
    localparam logic          HAS_PAR = (PARITY != PAR_NONE);

    logic                 tick;
    logic                 rx_m_q, rx_s_q;
    rx_state_e            state_q, state_d;
    logic [TW-1:0]        tc_q, tc_d;
    logic [BW-1:0]        bc_q, bc_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 s0_q, s0_d;
    logic                 s1_q, s1_d;
    logic                 par_q, par_d;
    logic                 ferr_q, ferr_d;
    logic                 maj;
    logic                 done;
    logic                 fe_new;
    logic                 pe_new;
    logic                 accept;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk50 (clk50),
        .nreset(nreset),
        .tick_o(tick)
    );

    // Two-flop synchroniser; the line idles high.
    always_ff @(posedge clk50 or negedge nreset) begin
        if (!nreset) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            rx_m_q <= rx;
            rx_s_q <= rx_m_q;
        end
    end

    // Next-state logic: sample counter, majority vote and bit sequencing.
    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        bc_d    = bc_q;
        shift_d = shift_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        done    = 1'b0;
        maj     = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
        fe_new  = ferr_q | ~maj;
        pe_new  = HAS_PAR & ((^shift_q ^ par_q) != IS_ODD);
        if (tick) begin
            if (state_q != ST_IDLE) begin
                tc_d = (tc_q == TC_LAST) ? '0 : tc_q + 1'b1;
                if (tc_q == TC_M0) s0_d = rx_s_q;
                if (tc_q == TC_M1) s1_d = rx_s_q;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = ST_START;
                        tc_d    = TW'(1);
                        ferr_d  = 1'b0;
                        par_d   = 1'b0;
                    end
                end
                ST_START: begin
                    if (tc_q == TC_M2 && maj) begin
                        state_d = ST_IDLE;
                        tc_d    = '0;
                    end else if (tc_q == TC_LAST) begin
                        state_d = ST_DATA;
                        bc_d    = '0;
                    end
                end
                ST_DATA: begin
                    if (tc_q == TC_M2) begin
                        shift_d = {maj, shift_q[DATA_BITS-1:1]};
                        bc_d    = bc_q + 1'b1;
                    end
                    if (tc_q == TC_LAST && bc_q == NBITS) begin
                        state_d = HAS_PAR ? ST_PARITY : ST_STOP;
                        bc_d    = '0;
                    end
                end
                ST_PARITY: begin
                    if (tc_q == TC_M2) par_d = maj;
                    if (tc_q == TC_LAST) state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (tc_q == TC_M2) begin
                        ferr_d = fe_new;
                        bc_d   = bc_q + 1'b1;
                        if (bc_q == SB_LAST) begin
                            state_d = ST_IDLE;
                            tc_d    = '0;
                            bc_d    = '0;
                            done    = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk50 or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            tc_q    <= '0;
            bc_q    <= '0;
            shift_q <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            bc_q    <= bc_d;
            shift_q <= shift_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
        end
    end

    assign accept = rx_valid & rx_ready;

    // Output holding register with valid/ready handshake and overrun.
    always_ff @(posedge clk50 or negedge nreset) begin
        if (!nreset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (done && (!rx_valid || accept)) begin
            rx_data    <= shift_q;
            rx_valid   <= 1'b1;
            frame_err  <= fe_new;
            parity_err <= pe_new;
            if (accept) overrun <= 1'b0;
        end else if (done) begin
            overrun <= 1'b1;
        end else if (accept) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for two receiver configurations,
// 8N1 defaults and even parity with two stop bits.
`timescale 1ns/1ps
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam int BIT = 432;
    localparam int DIV = 27;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       nreset;
    logic       rx_a, rx_b;
    logic       rdy_a, rdy_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, fe_a, pe_a, ovr_a;
    logic       valid_b, fe_b, pe_b, ovr_b;

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   t0     = -1;
    int   lat    = -1;
    bit   drop_a = 1'b0;

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param u_a (
        .clk50     (clk),
        .nreset    (nreset),
        .rx        (rx_a),
        .rx_data   (data_a),
        .rx_valid  (valid_a),
        .rx_ready  (rdy_a),
        .frame_err (fe_a),
        .parity_err(pe_a),
        .overrun   (ovr_a)
    );

    uart_rx_param #(
        .PARITY   (1),
        .STOP_BITS(2)
    ) u_b (
        .clk50     (clk),
        .nreset    (nreset),
        .rx        (rx_b),
        .rx_data   (data_b),
        .rx_valid  (valid_b),
        .rx_ready  (rdy_b),
        .frame_err (fe_b),
        .parity_err(pe_b),
        .overrun   (ovr_b)
    );

    task automatic check(
        input string       tag,
        input logic [15:0] got,
        input logic [15:0] exp
    );
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (drop_a) begin
            check("a_valid_drop", 16'(valid_a), 16'd0);
            drop_a = 1'b0;
        end
        if (valid_a && rdy_a) begin
            check("a_expected", 16'(qa.size() != 0), 16'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_data", 16'(data_a), 16'(e.data));
                check("a_fe", 16'(fe_a), 16'(e.fe));
                check("a_pe", 16'(pe_a), 16'(e.pe));
                if (t0 >= 0) begin
                    lat = cyc - t0;
                    t0  = -1;
                end
                drop_a = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid_b && rdy_b) begin
            check("b_expected", 16'(qb.size() != 0), 16'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check("b_data", 16'(data_b), 16'(e.data));
                check("b_fe", 16'(fe_b), 16'(e.fe));
                check("b_pe", 16'(pe_b), 16'(e.pe));
            end
        end
    end

    task automatic line(input bit to_b, input logic v);
        if (to_b) rx_b = v;
        else      rx_a = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send(
        input bit         to_b,
        input logic [7:0] d,
        input logic       par,
        input logic       stop,
        input int         nstop,
        input bit         keep
    );
        exp_t e;
        e.data = d;
        e.fe   = ~stop;
        e.pe   = to_b ? ((^d ^ par) != 1'b0) : 1'b0;
        if (keep) begin
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
        line(to_b, 1'b0);
        for (int i = 0; i < 8; i++) line(to_b, d[i]);
        if (to_b) line(to_b, par);
        for (int i = 0; i < nstop; i++) line(to_b, stop);
        line(to_b, 1'b1);
    endtask

    task automatic wait_empty(input bit to_b);
        int n;
        n = 0;
        while ((to_b ? qb.size() : qa.size()) != 0 && n < 2 * BIT) begin
            @(negedge clk);
            n++;
        end
        if (to_b) check("b_drain", 16'(qb.size()), 16'd0);
        else      check("a_drain", 16'(qa.size()), 16'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        nreset = 1'b0;
        rx_a   = 1'b1;
        rx_b   = 1'b1;
        rdy_a  = 1'b1;
        rdy_b  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", 16'(data_a), 16'd0);
        check("rst_valid", 16'(valid_a), 16'd0);
        check("rst_flags", 16'({fe_a, pe_a, ovr_a}), 16'd0);
        check("rst_sync", 16'(u_a.rx_s_q), 16'd1);
        nreset = 1'b1;
        repeat (5) @(negedge clk);

        t0 = cyc;
        send(1'b0, 8'hA5, 1'b0, 1'b1, 1, 1'b1);
        wait_empty(1'b0);
        check("a5_lat_lo", 16'(lat >= 4104 - DIV), 16'd1);
        check("a5_lat_hi", 16'(lat <= 4104 + 2 * DIV + 8), 16'd1);

        rx_a = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("fs_state", 16'(u_a.state_q), 16'(ST_IDLE));
        check("fs_valid", 16'(valid_a), 16'd0);
        send(1'b0, 8'h3C, 1'b0, 1'b1, 1, 1'b1);
        wait_empty(1'b0);

        send(1'b0, 8'h55, 1'b0, 1'b0, 1, 1'b1);
        line(1'b0, 1'b1);
        send(1'b0, 8'h12, 1'b0, 1'b1, 1, 1'b1);
        wait_empty(1'b0);

        rdy_a = 1'b0;
        send(1'b0, 8'h11, 1'b0, 1'b1, 1, 1'b1);
        send(1'b0, 8'h22, 1'b0, 1'b1, 1, 1'b0);
        check("ovr_data", 16'(data_a), 16'h11);
        check("ovr_flag", 16'(ovr_a), 16'd1);
        check("ovr_valid", 16'(valid_a), 16'd1);
        @(posedge clk);
        #1 rdy_a = 1'b1;
        @(posedge clk);
        #1 rdy_a = 1'b0;
        repeat (3) @(negedge clk);
        check("ovr_clear", 16'(ovr_a), 16'd0);
        wait_empty(1'b0);
        rdy_a = 1'b1;

        send(1'b1, 8'h07, 1'b0, 1'b1, 2, 1'b1);
        send(1'b1, 8'h07, 1'b1, 1'b1, 2, 1'b1);
        wait_empty(1'b1);

        v = 8'h81;
        line(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) line(1'b1, v[i]);
        rx_b = v[4];
        repeat (BIT / 2) @(negedge clk);
        nreset = 1'b0;
        #1;
        check("mrst_data_b", 16'(data_b), 16'd0);
        check("mrst_data_a", 16'(data_a), 16'd0);
        check("mrst_valid", 16'({valid_a, valid_b}), 16'd0);
        check("mrst_flags", 16'({fe_b, pe_b, ovr_b}), 16'd0);
        check("mrst_state", 16'(u_b.state_q), 16'(ST_IDLE));
        rx_b = 1'b1;
        repeat (5) @(negedge clk);
        nreset = 1'b1;
        repeat (5) @(negedge clk);
        send(1'b1, v, ^v, 1'b1, 2, 1'b1);
        wait_empty(1'b1);
        repeat (BIT) @(negedge clk);
        check("end_valid_b", 16'(valid_b), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
